// File: rtl/beh_rand_delay_pkg.sv
// -----------------------------------------------------------------------------
// beh_rand_delay_pkg
//   Shared types and helpers for the behavioural random-stall models.
//   - hs_dly_state_e : state encoding of the valid/ready delay scheduler
//   - LFSR_POLY      : Galois mask for x^32 + x^22 + x^2 + x + 1 (right-shift form)
//   - beh_lfsr_next  : one step of the 32-bit Galois LFSR
// -----------------------------------------------------------------------------
package beh_rand_delay_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRESENT = 2'd2
    } hs_dly_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Right-shift Galois step: the bit shifted out feeds back into the tap mask.
    function automatic logic [31:0] beh_lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage : beh_rand_delay_pkg

// File: rtl/beh_lfsr.sv
// -----------------------------------------------------------------------------
// beh_lfsr
//   Free-running Galois LFSR, advances every clock after reset.
//   A zero SEED is replaced by 1 so the register can never lock up.
// Ports
//   clk     in   1      clock, rising edge
//   rst_n   in   1      asynchronous active-low reset (loads the seed)
//   lfsr_q  out  WIDTH  current LFSR state
// -----------------------------------------------------------------------------
module beh_lfsr
    import beh_rand_delay_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'hACE1_2468),
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] lfsr_q
);

    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] lfsr_d;

    generate
        if (WIDTH == 32) begin : g_pkg_step
            always_comb lfsr_d = beh_lfsr_next(lfsr_q);
        end else begin : g_generic_step
            always_comb lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? POLY : '0);
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED_NZ;
        else        lfsr_q <= lfsr_d;
    end

endmodule : beh_lfsr

// File: rtl/beh_rand_hs_delay.sv
// -----------------------------------------------------------------------------
// beh_rand_hs_delay
//   Behavioural stall model for a valid/ready channel. A single-entry buffer
//   accepts one beat, holds it for a random N cycles (N in [min,max]) and then
//   presents it downstream. With cfg_enable=0 and no beat held it is a
//   zero-latency combinational wire.
//
//   Optional build macro BEH_RAND_HS_DELAY_STATS_EN adds saturating counters:
//     stat_beats        : accepted beats
//     stat_stall_cycles : cycles in WAIT, plus PRESENT with out_ready=0
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   cfg_enable               1=insert delays, 0=pass-through (from IDLE only)
//   cfg_fixed                1=draw delay once and reuse, 0=redraw per beat
//   cfg_min_dly/cfg_max_dly  delay range in cycles
//   in_valid/in_ready/in_data      upstream channel
//   out_valid/out_ready/out_data   downstream channel
//   busy                     a beat is held (state != IDLE)
//   cfg_err                  registered flag, 1 while cfg_max_dly < cfg_min_dly
// -----------------------------------------------------------------------------
module beh_rand_hs_delay
    import beh_rand_delay_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          CNT_WIDTH  = 8,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic                  cfg_fixed,
    input  logic [CNT_WIDTH-1:0]  cfg_min_dly,
    input  logic [CNT_WIDTH-1:0]  cfg_max_dly,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  cfg_err
`ifdef BEH_RAND_HS_DELAY_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stall_cycles
`endif
);

    hs_dly_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fixed_valid_q, fixed_valid_d;
    logic [CNT_WIDTH-1:0]  fixed_dly_q, fixed_dly_d;
    logic                  cfg_fixed_q;
    logic                  cfg_err_q;
    logic                  accept;

    // ---------------------------------------------------------------- LFSR
    logic [31:0] lfsr_q;

    beh_lfsr #(
        .WIDTH (32),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_q (lfsr_q)
    );

    // ---------------------------------------------------------- delay draw
    // The range is one bit wider than the counter so max-min+1 cannot wrap
    // (e.g. min=0, max=255 gives 256).
    logic                 cfg_bad;
    logic [CNT_WIDTH:0]   dly_range;
    logic [CNT_WIDTH:0]   dly_rem;
    logic [CNT_WIDTH:0]   dly_sum;
    logic [CNT_WIDTH-1:0] draw_dly;
    logic [CNT_WIDTH-1:0] acc_dly;

    assign cfg_bad = (cfg_max_dly < cfg_min_dly);

    always_comb begin
        // An inverted range is forced to 1 so the modulo never divides by zero.
        dly_range = cfg_bad ? (CNT_WIDTH+1)'(1)
                            : ({1'b0, cfg_max_dly} - {1'b0, cfg_min_dly} + (CNT_WIDTH+1)'(1));
        dly_rem   = lfsr_q[CNT_WIDTH:0] % dly_range;
        // Never exceeds cfg_max_dly, so the top bit of the sum is always zero.
        dly_sum   = {1'b0, cfg_min_dly} + dly_rem;
        draw_dly  = cfg_bad ? cfg_min_dly : dly_sum[CNT_WIDTH-1:0];
        acc_dly   = (cfg_fixed && fixed_valid_q) ? fixed_dly_q : draw_dly;
    end

    logic unused_bits;
    assign unused_bits = ^{lfsr_q[31:CNT_WIDTH+1], dly_sum[CNT_WIDTH]};

    // ----------------------------------------------------------------- FSM
    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = data_q;

        unique case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept = 1'b1;
                        data_d = in_data;
                        if (acc_dly == '0) begin
                            state_d = PRESENT;
                        end else begin
                            cnt_d   = acc_dly;
                            state_d = WAIT;
                        end
                    end
                end else begin
                    out_valid = in_valid;
                    out_data  = in_data;
                    in_ready  = out_ready;
                end
            end
            WAIT: begin
                // Count reaches 1 on the last waiting cycle; the beat is then
                // visible d+1 cycles after the accepting edge.
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q <= CNT_WIDTH'(1)) state_d = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fixed-delay latch: invalidated by disabling the block or by cfg_fixed
    // falling, so re-entering fixed mode always takes a fresh draw.
    always_comb begin
        fixed_valid_d = fixed_valid_q;
        fixed_dly_d   = fixed_dly_q;
        if (!cfg_enable || (cfg_fixed_q && !cfg_fixed)) begin
            fixed_valid_d = 1'b0;
        end else if (accept && cfg_fixed && !fixed_valid_q) begin
            fixed_valid_d = 1'b1;
            fixed_dly_d   = draw_dly;
        end
    end

    // NOTE: the payload register is reset too: out_data is observable in IDLE
    // and must read zero after reset rather than stale or unknown data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            data_q        <= '0;
            fixed_valid_q <= 1'b0;
            fixed_dly_q   <= '0;
            cfg_fixed_q   <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            fixed_valid_q <= fixed_valid_d;
            fixed_dly_q   <= fixed_dly_d;
            cfg_fixed_q   <= cfg_fixed;
            cfg_err_q     <= cfg_bad;
        end
    end

    assign busy    = (state_q != IDLE);
    assign cfg_err = cfg_err_q;

    // ---------------------------------------------------------- statistics
`ifdef BEH_RAND_HS_DELAY_STATS_EN
    logic [31:0] stat_beats_q, stat_stall_q;
    logic        beat_inc, stall_inc;

    assign beat_inc  = in_valid && in_ready;
    assign stall_inc = (state_q == WAIT) || ((state_q == PRESENT) && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (beat_inc && (stat_beats_q != '1))  stat_beats_q <= stat_beats_q + 32'd1;
            if (stall_inc && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_beats        = stat_beats_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule : beh_rand_hs_delay

// File: tb/tb_beh_rand_hs_delay.sv
// -----------------------------------------------------------------------------
// tb_beh_rand_hs_delay
//   Scoreboard bench for beh_rand_hs_delay: the driver pushes the expected
//   payload and latency at every accept, a forked monitor pops and compares
//   whenever the DUT completes a downstream handshake.
// -----------------------------------------------------------------------------
module tb_beh_rand_hs_delay;

    localparam int          DW   = 32;
    localparam int          CW   = 8;
    localparam logic [31:0] SEED = 32'hACE1_2468;
    localparam logic [31:0] POLY = 32'h8020_0003;

    typedef struct {
        logic [31:0] data;
        int          exp_lat;
        int          acc_cyc;
    } sb_item_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_enable = 1'b1;
    logic          cfg_fixed = 1'b0;
    logic [CW-1:0] cfg_min_dly = '0;
    logic [CW-1:0] cfg_max_dly = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          cfg_err;

    always #5 clk = ~clk;

    beh_rand_hs_delay #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_enable  (cfg_enable),
        .cfg_fixed   (cfg_fixed),
        .cfg_min_dly (cfg_min_dly),
        .cfg_max_dly (cfg_max_dly),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    // Cycle counter and reference LFSR (x^32+x^22+x^2+x+1, Galois, right shift).
    int          cyc = 0;
    logic [31:0] m_lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? POLY : 32'h0);
    end

    int       checks = 0;
    int       failures = 0;
    sb_item_t sb_q[$];
    int       lat_log[$];
    bit       mon_en = 1'b0;
    bit       fv_m = 1'b0;
    int       fd_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_draw(input logic [31:0] m, input int mn, input int mx);
        int rng;
        if (mx < mn) return mn;
        rng = mx - mn + 1;
        return mn + (int'(m[CW:0]) % rng);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fixed(input logic v);
        if (cfg_fixed && !v) fv_m = 1'b0;
        cfg_fixed = v;
    endtask

    task automatic set_enable(input logic v);
        if (!v) fv_m = 1'b0;
        cfg_enable = v;
    endtask

    // Drive one beat; lat_ovr >= 0 gives a hand-computed latency, otherwise
    // the latency comes from the reference draw.
    task automatic send(input logic [31:0] v, input int lat_ovr, output int acc);
        bit got;
        int d;
        got      = 1'b0;
        acc      = -1;
        in_valid = 1'b1;
        in_data  = v;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                acc = cyc;
                if (cfg_fixed && fv_m) begin
                    d = fd_m;
                end else begin
                    d = model_draw(m_lfsr, int'(cfg_min_dly), int'(cfg_max_dly));
                    if (cfg_fixed) begin
                        fv_m = 1'b1;
                        fd_m = d;
                    end
                end
                sb_q.push_back('{data: v, exp_lat: (lat_ovr >= 0) ? lat_ovr : d + 1, acc_cyc: cyc});
            end
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000 && sb_q.size() != 0; t++) @(negedge clk);
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic monitor_loop();
        bit          head_seen;
        bit          prev_hold;
        logic [31:0] prev_data;
        sb_item_t    it;
        int          lat;
        head_seen = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (prev_hold)
                    check("hold_stable", {out_valid, out_data}, {1'b1, prev_data});
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_out_valid", 64'd1, 64'd0);
                    end else begin
                        if (!head_seen) begin
                            head_seen = 1'b1;
                            lat = cyc - sb_q[0].acc_cyc;
                            lat_log.push_back(lat);
                            check("latency", 64'(lat), 64'(sb_q[0].exp_lat));
                        end
                        if (out_ready) begin
                            it = sb_q.pop_front();
                            check("out_data", out_data, it.data);
                            head_seen = 1'b0;
                        end
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    endtask

    task automatic pt_vec(input logic iv, input logic [31:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        check("passthrough", {out_valid, out_data, in_ready}, {iv, id, ordy});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, first_acc, last_acc;
        int mn, mx, diff, seen;
        logic [7:0] mask;

        fork
            monitor_loop();
        join_none

        // ---- reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // ---- 1: min=max=3, single beat, out_valid 4 cycles after accept
        cfg_min_dly = 8'd3;
        cfg_max_dly = 8'd3;
        tick();
        send(32'h0000_00A5, 4, acc);
        wait_drain();

        // ---- 2: zero delay, 100 back-to-back beats at 1 beat / 2 cycles
        cfg_min_dly = 8'd0;
        cfg_max_dly = 8'd0;
        tick();
        first_acc = 0;
        last_acc  = 0;
        for (int i = 0; i < 100; i++) begin
            send(32'h0000_0100 + 32'(i), 1, acc);
            if (i == 0) first_acc = acc;
            last_acc = acc;
        end
        check("t2_throughput", 64'(last_acc - first_acc), 64'd198);
        wait_drain();

        // ---- 3: random delays in [2,9], order preserved
        cfg_min_dly = 8'd2;
        cfg_max_dly = 8'd9;
        tick();
        lat_log.delete();
        for (int i = 0; i < 1000; i++) send(32'h0003_0000 + 32'(i), -1, acc);
        wait_drain();
        mn   = 1000;
        mx   = -1;
        mask = '0;
        foreach (lat_log[i]) begin
            if (lat_log[i] - 1 < mn) mn = lat_log[i] - 1;
            if (lat_log[i] - 1 > mx) mx = lat_log[i] - 1;
            if (lat_log[i] - 1 >= 2 && lat_log[i] - 1 <= 9) mask[lat_log[i] - 3] = 1'b1;
        end
        check("t3_min_delay_ge_2", 64'(mn >= 2), 64'd1);
        check("t3_max_delay_le_9", 64'(mx <= 9), 64'd1);
        check("t3_all_values_seen", 64'(mask), 64'hFF);

        // ---- 4: fixed mode, then re-arm via cfg_fixed 1->0->1
        cfg_min_dly = 8'd1;
        cfg_max_dly = 8'd15;
        set_fixed(1'b1);
        tick();
        lat_log.delete();
        for (int i = 0; i < 50; i++) send(32'h0004_0000 + 32'(i), -1, acc);
        wait_drain();
        diff = 0;
        foreach (lat_log[i]) if (lat_log[i] != lat_log[0]) diff++;
        check("t4_fixed_identical", 64'(diff), 64'd0);
        check("t4_fixed_in_range", 64'(lat_log[0] >= 2 && lat_log[0] <= 16), 64'd1);
        set_fixed(1'b0);
        repeat (3) tick();
        set_fixed(1'b1);
        repeat (5) tick();
        lat_log.delete();
        for (int i = 0; i < 5; i++) send(32'h0004_1000 + 32'(i), -1, acc);
        wait_drain();
        diff = 0;
        foreach (lat_log[i]) if (lat_log[i] != lat_log[0]) diff++;
        check("t4_redraw_identical", 64'(diff), 64'd0);
        set_fixed(1'b0);
        tick();

        // ---- 5: back-pressure in PRESENT for 20 cycles
        cfg_min_dly = 8'd1;
        cfg_max_dly = 8'd1;
        out_ready   = 1'b0;
        tick();
        send(32'h5555_0005, 2, acc);
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        check("t5_reach_present", 64'(out_valid), 64'd1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("t5_stall_hold", {out_valid, in_ready, out_data}, {1'b1, 1'b0, 32'h5555_0005});
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_idle_after_release", {busy, out_valid, in_ready}, 3'b001);
        wait_drain();

        // ---- 6a: inverted range -> cfg_err, delay = min
        cfg_min_dly = 8'd5;
        cfg_max_dly = 8'd2;
        @(posedge clk);
        @(negedge clk);
        check("t6_cfg_err_set", 64'(cfg_err), 64'd1);
        tick();
        send(32'h0000_0066, 6, acc);
        wait_drain();
        cfg_min_dly = 8'd2;
        cfg_max_dly = 8'd5;
        @(posedge clk);
        @(negedge clk);
        check("t6_cfg_err_clear", 64'(cfg_err), 64'd0);

        // ---- 6b: pass-through from IDLE
        mon_en = 1'b0;
        tick();
        set_enable(1'b0);
        pt_vec(1'b1, 32'hDEAD_BEEF, 1'b1);
        pt_vec(1'b1, 32'h0000_1234, 1'b0);
        pt_vec(1'b0, 32'h0000_0077, 1'b1);
        pt_vec(1'b0, 32'h0000_0000, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        set_enable(1'b1);
        tick();

        // ---- 6c: reset asserted while a beat waits
        cfg_min_dly = 8'd10;
        cfg_max_dly = 8'd10;
        tick();
        in_valid = 1'b1;
        in_data  = 32'h0000_0BAD;
        for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
        tick();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1 check("t6_reset_outputs", {out_valid, out_data, busy, cfg_err}, 35'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("t6_beat_dropped", 64'(seen), 64'd0);

        // Recovery after reset uses the re-seeded LFSR.
        mon_en      = 1'b1;
        cfg_min_dly = 8'd2;
        cfg_max_dly = 8'd2;
        tick();
        send(32'h0000_0777, 3, acc);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_beh_rand_hs_delay
